l2_write_buffer: RTL and testbench

//  Posted-write buffer between the I/D arbiter's L2-side port and the L2 cache.
//  - Absorbs dirty-line writebacks with 1-cycle response.
//  - Serves reads that hit a buffered line; bypasses reads that miss straight to L2.
//  - Drains buffered lines to L2 in FIFO order whenever the L2 port is free.

---
 rtl/l2_write_buffer_pkg.sv | 29 ++
 rtl/wb_cam_fifo.sv | 99 +++++++++
 rtl/l2_write_buffer.sv | 151 +++++++++++++++
 tb/tb_l2_write_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_write_buffer_pkg.sv
// rtl/l2_write_buffer_pkg.sv - shared types and constants for the L2 posted-write buffer
package l2_write_buffer_pkg;

  localparam int WB_DEPTH       = 4;
  localparam int WB_OFFSET_BITS = 4;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;
  typedef logic [11:0]  lc3b_line_tag;

  typedef struct packed {
    logic           valid;
    lc3b_line_tag   tag;
    lc3b_cache_line line;
  } wb_entry_t;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_RESP = 2'd1,
    U_MISS = 2'd2,
    U_DONE = 2'd3
  } up_state_t;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_DRAIN = 1'b1
  } dn_state_t;

endpackage

// File: rtl/wb_cam_fifo.sv
// rtl/wb_cam_fifo.sv - circular FIFO of buffered lines with parallel tag lookup and head lock
module wb_cam_fifo
  import l2_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int TAG_W  = 12,
  parameter int LINE_W = 128,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic              hit_head,
  output logic              hit_locked,
  output logic [LINE_W-1:0] hit_line,
  input  logic              merge,
  input  logic [LINE_W-1:0] merge_line,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [LINE_W-1:0] push_line,
  input  logic              lock,
  input  logic              pop,
  output logic [TAG_W-1:0]  head_tag,
  output logic [LINE_W-1:0] head_line,
  output logic              empty,
  output logic              full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              valid [DEPTH];
  logic [TAG_W-1:0]  tags  [DEPTH];
  logic [LINE_W-1:0] lines [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     hit_idx;
  logic [CW-1:0]     count;
  logic              head_lock;

  // Tags are unique among valid entries, so at most one slot can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tags[i] == lookup_tag) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign hit_head   = hit && (hit_idx == head);
  assign hit_locked = hit_head && head_lock;
  assign hit_line   = lines[hit_idx];
  assign head_tag   = tags[head];
  assign head_line  = lines[head];
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      head_lock <= 1'b0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        head_lock   <= 1'b0;
      end else if (lock) begin
        head_lock <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity alone defines occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail]  <= push_tag;
      lines[tail] <= push_line;
    end else if (merge) begin
      lines[hit_idx] <= merge_line;
    end
  end

endmodule

// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - posted-write buffer between the arbiter L2 port and the L2 cache
module l2_write_buffer
  import l2_write_buffer_pkg::*;
#(
  parameter int DEPTH       = WB_DEPTH,
  parameter int OFFSET_BITS = WB_OFFSET_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  up_address,
  input  logic         up_read,
  input  logic         up_write,
  input  logic [127:0] up_wdata,
  output logic [127:0] up_rdata,
  output logic         up_mem_resp,
  output logic [15:0]  dn_address,
  output logic         dn_read,
  output logic         dn_write,
  output logic [127:0] dn_wdata,
  input  logic [127:0] dn_rdata,
  input  logic         dn_mem_resp
);

  localparam int TAG_W = 16 - OFFSET_BITS;

  up_state_t          ustate, u_next;
  dn_state_t          dstate, d_next;
  logic [TAG_W-1:0]   up_tag;
  logic [TAG_W-1:0]   head_tag;
  logic [127:0]       head_line;
  logic [127:0]       hit_line;
  logic               hit, hit_head, hit_locked, empty, full;
  logic               wr_req, wr_merge, wr_push, rd_hit, rd_miss;
  logic               miss_issue, miss_done, drain_start, drain_done;
  logic               dn_read_q, dn_write_q;
  logic [15:0]        dn_address_q;
  logic [127:0]       dn_wdata_q, up_rdata_q;

  assign up_tag = up_address[15:OFFSET_BITS];

  wb_cam_fifo #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .LINE_W (128)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_tag (up_tag),
    .hit        (hit),
    .hit_head   (hit_head),
    .hit_locked (hit_locked),
    .hit_line   (hit_line),
    .merge      (wr_merge),
    .merge_line (up_wdata),
    .push       (wr_push),
    .push_tag   (up_tag),
    .push_line  (up_wdata),
    .lock       (drain_start),
    .pop        (drain_done),
    .head_tag   (head_tag),
    .head_line  (head_line),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ustate <= U_IDLE;
    else          ustate <= u_next;
  end

  always_comb begin
    u_next = ustate;
    case (ustate)
      U_IDLE: begin
        if (rd_hit)                   u_next = U_RESP;
        else if (rd_miss)             u_next = U_MISS;
        else if (wr_merge || wr_push) u_next = U_RESP;
      end
      U_MISS:  if (miss_done) u_next = U_RESP;
      U_RESP:  u_next = U_DONE;
      U_DONE:  u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  // Reads win over writes; a write to the line being drained waits for its pop.
  always_comb begin
    rd_hit      = (ustate == U_IDLE) && up_read && hit;
    rd_miss     = (ustate == U_IDLE) && up_read && !hit;
    wr_req      = (ustate == U_IDLE) && up_write && !up_read;
    wr_merge    = wr_req && hit && !hit_locked;
    wr_push     = wr_req && !hit && !full;
    miss_issue  = (ustate == U_MISS) && (dstate == D_IDLE) && !dn_read_q;
    miss_done   = (ustate == U_MISS) && dn_read_q && dn_mem_resp;
    up_mem_resp = (ustate == U_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dstate <= D_IDLE;
    else          dstate <= d_next;
  end

  always_comb begin
    d_next = dstate;
    case (dstate)
      D_IDLE:  if (drain_start) d_next = D_DRAIN;
      D_DRAIN: if (drain_done)  d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // A read miss that is waiting, or about to start waiting, holds off new drains.
  always_comb begin
    drain_start = (dstate == D_IDLE) && !empty && (ustate != U_MISS) && !rd_miss;
    drain_done  = (dstate == D_DRAIN) && dn_mem_resp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_read_q    <= 1'b0;
      dn_write_q   <= 1'b0;
      dn_address_q <= '0;
      dn_wdata_q   <= '0;
      up_rdata_q   <= '0;
    end else begin
      if (drain_start) begin
        dn_write_q   <= 1'b1;
        dn_address_q <= {head_tag, {OFFSET_BITS{1'b0}}};
        // A merge landing on the head this same cycle must reach L2.
        dn_wdata_q   <= (wr_merge && hit_head) ? up_wdata : head_line;
      end else if (drain_done) begin
        dn_write_q <= 1'b0;
      end
      if (miss_issue) begin
        dn_read_q    <= 1'b1;
        dn_address_q <= up_address;
      end else if (miss_done) begin
        dn_read_q  <= 1'b0;
        up_rdata_q <= dn_rdata;
      end
      if (rd_hit) up_rdata_q <= hit_line;
    end
  end

  assign dn_read    = dn_read_q;
  assign dn_write   = dn_write_q;
  assign dn_address = dn_address_q;
  assign dn_wdata   = dn_wdata_q;
  assign up_rdata   = up_rdata_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb/tb_l2_write_buffer.sv - directed self-checking bench for l2_write_buffer
module tb_l2_write_buffer;

  logic         clk;
  logic         reset_n;
  logic [15:0]  up_address;
  logic         up_read;
  logic         up_write;
  logic [127:0] up_wdata;
  logic [127:0] up_rdata;
  logic         up_mem_resp;
  logic [15:0]  dn_address;
  logic         dn_read;
  logic         dn_write;
  logic [127:0] dn_wdata;
  logic [127:0] dn_rdata;
  logic         dn_mem_resp;

  int checks   = 0;
  int failures = 0;

  l2_write_buffer #(.DEPTH(4), .OFFSET_BITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .up_address  (up_address),
    .up_read     (up_read),
    .up_write    (up_write),
    .up_wdata    (up_wdata),
    .up_rdata    (up_rdata),
    .up_mem_resp (up_mem_resp),
    .dn_address  (dn_address),
    .dn_read     (dn_read),
    .dn_write    (dn_write),
    .dn_wdata    (dn_wdata),
    .dn_rdata    (dn_rdata),
    .dn_mem_resp (dn_mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fill_line(input int i);
    logic [7:0] b;
    b = 8'(8'h10 + i);
    return {16{b}};
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [127:0] d, output int lat);
    up_address = a;
    up_wdata   = d;
    up_write   = 1'b1;
    lat        = 0;
    while (!up_mem_resp && lat < 30) begin
      tick();
      lat++;
    end
    up_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [15:0] a, output logic [127:0] d, output int lat,
                         output logic saw_dn_read);
    up_address  = a;
    up_read     = 1'b1;
    lat         = 0;
    saw_dn_read = 1'b0;
    while (!up_mem_resp && lat < 30) begin
      tick();
      lat++;
      if (dn_read) saw_dn_read = 1'b1;
    end
    d       = up_rdata;
    up_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain_expect(input string tag, input logic [15:0] a, input logic [127:0] d,
                              input int hold);
    int n;
    n = 0;
    while (!dn_write && n < 20) begin
      tick();
      n++;
    end
    repeat (hold) tick();
    chk({tag, "_dn_write"}, dn_write, 1'b1);
    chk({tag, "_dn_addr"}, dn_address, a);
    chk({tag, "_dn_wdata"}, dn_wdata, d);
    chk({tag, "_no_dn_read"}, dn_read, 1'b0);
    dn_mem_resp = 1'b1;
    tick();
    dn_mem_resp = 1'b0;
    chk({tag, "_released"}, dn_write, 1'b0);
  endtask

  initial begin
    int           lat;
    logic         seen;
    logic [127:0] rdata;
    logic [127:0] line_a, line_b, line_c, line_d, line_e, line_f, line_g, line_h, line_5a;

    line_a  = {8{16'hA5A1}};
    line_b  = {4{32'hB0B0_B0B0}};
    line_c  = {4{32'hC0C0_C001}};
    line_d  = {8{16'hD00D}};
    line_e  = {8{16'hE1E2}};
    line_f  = {8{16'hF00F}};
    line_g  = {8{16'h6161}};
    line_h  = {8{16'h4848}};
    line_5a = {8{16'h5A5A}};

    reset_n     = 1'b0;
    up_address  = '0;
    up_read     = 1'b0;
    up_write    = 1'b0;
    up_wdata    = '0;
    dn_rdata    = '0;
    dn_mem_resp = 1'b0;
    tick();
    tick();
    chk("rst_up_mem_resp", up_mem_resp, 1'b0);
    chk("rst_up_rdata", up_rdata, '0);
    chk("rst_dn_read", dn_read, 1'b0);
    chk("rst_dn_write", dn_write, 1'b0);
    chk("rst_dn_address", dn_address, '0);
    chk("rst_dn_wdata", dn_wdata, '0);
    reset_n = 1'b1;
    tick();

    // Single write, then its drain held for three cycles before L2 answers.
    do_write(16'h1230, line_a, lat);
    chk("wr1230_lat", lat, 1);
    drain_expect("drain1230", 16'h1230, line_a, 3);
    tick();
    chk("idle_after_pop", dn_write, 1'b0);

    // Fill all four entries with L2 stalled, then a fifth write must wait for a pop.
    for (int i = 0; i < 4; i++) begin
      do_write(16'(i * 16), fill_line(i), lat);
      chk("fill_lat", lat, 1);
    end
    up_address = 16'h0040;
    up_wdata   = fill_line(4);
    up_write   = 1'b1;
    seen       = 1'b0;
    repeat (5) begin
      tick();
      if (up_mem_resp) seen = 1'b1;
    end
    chk("full_stall", seen, 1'b0);
    chk("full_drain_addr", dn_address, 16'h0000);
    dn_mem_resp = 1'b1;
    tick();
    dn_mem_resp = 1'b0;
    chk("full_pop_cycle_no_resp", up_mem_resp, 1'b0);
    tick();
    chk("full_accept_next", up_mem_resp, 1'b1);
    chk("full_next_drain", dn_address, 16'h0010);
    up_write = 1'b0;
    tick();
    tick();
    drain_expect("drain0010", 16'h0010, fill_line(1), 0);
    drain_expect("drain0020", 16'h0020, fill_line(2), 0);
    drain_expect("drain0030", 16'h0030, fill_line(3), 1);
    drain_expect("drain0040", 16'h0040, fill_line(4), 0);

    // Read hit and merge on a buffered line that is not the one draining.
    do_write(16'h3000, line_d, lat);
    chk("wr3000_lat", lat, 1);
    do_write(16'h2000, line_b, lat);
    chk("wr2000_lat", lat, 1);
    do_read(16'h2008, rdata, lat, seen);
    chk("rdhit_lat", lat, 1);
    chk("rdhit_data", rdata, line_b);
    chk("rdhit_no_dn_read", seen, 1'b0);
    do_write(16'h2000, line_c, lat);
    chk("merge_lat", lat, 1);
    drain_expect("drain3000", 16'h3000, line_d, 0);
    drain_expect("drain2000_merged", 16'h2000, line_c, 0);

    // Read miss arriving while a drain is in flight.
    do_write(16'h6000, line_e, lat);
    chk("wr6000_lat", lat, 1);
    up_address = 16'h4000;
    up_read    = 1'b1;
    repeat (3) tick();
    chk("miss_wait_no_dn_read", dn_read, 1'b0);
    chk("miss_wait_drain_held", dn_write, 1'b1);
    dn_mem_resp = 1'b1;
    tick();
    dn_mem_resp = 1'b0;
    chk("miss_drain_done_no_read", dn_read, 1'b0);
    tick();
    chk("miss_dn_read", dn_read, 1'b1);
    chk("miss_dn_addr", dn_address, 16'h4000);
    chk("miss_no_dn_write", dn_write, 1'b0);
    dn_rdata    = line_5a;
    dn_mem_resp = 1'b1;
    tick();
    dn_mem_resp = 1'b0;
    chk("miss_resp", up_mem_resp, 1'b1);
    chk("miss_rdata", up_rdata, line_5a);
    chk("miss_dn_read_drop", dn_read, 1'b0);
    up_read = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a drain.
    do_write(16'h7000, line_f, lat);
    chk("wr7000_lat", lat, 1);
    chk("pre_reset_drain", dn_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_dn_write", dn_write, 1'b0);
    chk("async_rst_dn_address", dn_address, '0);
    chk("async_rst_dn_wdata", dn_wdata, '0);
    chk("async_rst_up_rdata", up_rdata, '0);
    tick();
    reset_n = 1'b1;
    seen    = 1'b0;
    repeat (6) begin
      tick();
      if (dn_write) seen = 1'b1;
    end
    chk("post_reset_no_drain", seen, 1'b0);

    // Write to the tag being drained waits for the pop, then allocates afresh.
    do_write(16'h8000, line_g, lat);
    chk("wr8000_lat", lat, 1);
    up_address = 16'h8000;
    up_wdata   = line_h;
    up_write   = 1'b1;
    seen       = 1'b0;
    repeat (4) begin
      tick();
      if (up_mem_resp) seen = 1'b1;
    end
    chk("locked_stall", seen, 1'b0);
    chk("locked_drain_data", dn_wdata, line_g);
    dn_mem_resp = 1'b1;
    tick();
    dn_mem_resp = 1'b0;
    chk("locked_pop_cycle_no_resp", up_mem_resp, 1'b0);
    tick();
    chk("locked_accept", up_mem_resp, 1'b1);
    up_write = 1'b0;
    tick();
    tick();
    drain_expect("redrain8000", 16'h8000, line_h, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
